// File: rtl/mod12_cascade_monitor.sv
// Watches a 4-bit mod-12 counter and its load strobe. Emits the 11->0 carry and
// advances a mod-HI_MOD cascade digit. Flags illegal steps and out-of-range values.
module mod12_cascade_monitor #(
    parameter int HI_MOD = 5,
    parameter int HI_W   = 3,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       q_in,
    input  logic             load_in,
    output logic             carry,
    output logic             tc,
    output logic [HI_W-1:0]  hi_count,
    output logic             step_err,
    output logic             oor,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {PRIME, TRACK, FAULT} state_t;

    state_t           state_q;
    logic [3:0]       q_prev_q;
    logic             load_prev_q;
    logic             carry_q;
    logic             tc_q;
    logic [HI_W-1:0]  hi_count_q;
    logic             step_err_q;
    logic             oor_q;
    logic             fault_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic             in_oor;
    logic             is_wrap;
    logic             is_inc;
    logic             hi_last;
    logic [ERR_W-1:0] err_cnt_d;

    always_comb begin
        in_oor    = q_in > 4'd11;
        is_wrap   = (q_prev_q == 4'd11) && (q_in == 4'd0);
        is_inc    = (q_prev_q <= 4'd10) && (q_in == q_prev_q + 4'd1);
        hi_last   = hi_count_q == HI_W'(HI_MOD - 1);
        err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
    end

    // load_prev_q belongs to the q_prev -> q_in transition being judged now,
    // since the counter applies a load on the same edge this block samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PRIME;
            q_prev_q    <= 4'd0;
            load_prev_q <= 1'b0;
            carry_q     <= 1'b0;
            tc_q        <= 1'b0;
            hi_count_q  <= '0;
            step_err_q  <= 1'b0;
            oor_q       <= 1'b0;
            fault_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            q_prev_q    <= q_in;
            load_prev_q <= load_in;
            carry_q     <= 1'b0;
            tc_q        <= 1'b0;
            step_err_q  <= 1'b0;
            oor_q       <= 1'b0;
            case (state_q)
                PRIME: begin
                    if (in_oor) begin
                        state_q   <= FAULT;
                        fault_q   <= 1'b1;
                        oor_q     <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                    end else begin
                        state_q   <= TRACK;
                    end
                end
                TRACK: begin
                    if (in_oor) begin
                        state_q   <= FAULT;
                        fault_q   <= 1'b1;
                        oor_q     <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                    end else if (load_prev_q) begin
                        state_q   <= TRACK;
                    end else if (is_wrap) begin
                        carry_q    <= 1'b1;
                        tc_q       <= hi_last;
                        hi_count_q <= hi_last ? '0 : hi_count_q + HI_W'(1);
                    end else if (!is_inc) begin
                        step_err_q <= 1'b1;
                        err_cnt_q  <= err_cnt_d;
                    end
                end
                FAULT: begin
                    // Only a legal reload brings the counter back under tracking.
                    if (load_prev_q && !in_oor) begin
                        state_q <= TRACK;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= PRIME;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign carry    = carry_q;
    assign tc       = tc_q;
    assign hi_count = hi_count_q;
    assign step_err = step_err_q;
    assign oor      = oor_q;
    assign fault    = fault_q;
    assign err_cnt  = err_cnt_q;

endmodule
